// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/interrupt controller with mstatus/mtvec/mepc/mcause and registered PC redirect.
// Define OV_TRAP_EN to let checked signed add/sub overflow raise a synchronous exception.
module trap_ctrl #(
    parameter logic [31:0] VEC_BASE    = 32'h0000_0008,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] pc,
    input  logic        inst_valid,
    input  logic        ov,
    input  logic        ov_chk,
    input  logic        ill,
    input  logic        ecall,
    input  logic        mret,
    input  logic        ext_irq,
    input  logic        csr_we,
    input  logic [1:0]  csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        cancel,
    output logic        redirect,
    output logic [31:0] redirect_pc
);
    typedef enum logic {RUN, REDIR} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic mie, mpie;
    logic [31:0] mtvec, mepc, mcause, cause;
    logic irq_s, ov_exc, trap, do_mret, wr;
`ifdef OV_TRAP_EN
    assign ov_exc = ov_chk & ov;
`else
    logic unused_ov;
    assign unused_ov = ov & ov_chk;
    assign ov_exc = 1'b0;
`endif
    assign irq_s = sync_q[SYNC_STAGES-1];
    always_comb begin
        trap      = (state == RUN) & inst_valid & (ill | ecall | ov_exc | (irq_s & mie));
        cause     = ill ? 32'h2 : ecall ? 32'hB : ov_exc ? 32'h18 : 32'h8000_000B;
        do_mret   = (state == RUN) & inst_valid & mret & ~trap;
        cancel    = (state == REDIR) | trap;
        wr        = csr_we & inst_valid & ~cancel & ~do_mret;
        csr_rdata = csr_addr == 2'd0 ? {24'd0, mpie, 3'd0, mie, 3'd0} :
                    csr_addr == 2'd1 ? mtvec :
                    csr_addr == 2'd2 ? mepc : mcause;
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= RUN;
            sync_q      <= '0;
            mie         <= 1'b0;
            mpie        <= 1'b0;
            mtvec       <= VEC_BASE;
            mepc        <= '0;
            mcause      <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq};
            if (state == REDIR) begin
                state    <= RUN;
                redirect <= 1'b0;
            end else if (trap) begin
                mepc        <= pc;
                mcause      <= cause;
                mpie        <= mie;
                mie         <= 1'b0;
                redirect_pc <= mtvec;
                redirect    <= 1'b1;
                state       <= REDIR;
            end else if (do_mret) begin
                mie         <= mpie;
                mpie        <= 1'b1;
                redirect_pc <= mepc;
                redirect    <= 1'b1;
                state       <= REDIR;
            end else if (wr) begin
                // only MIE/MPIE exist in mstatus; mtvec stays word aligned
                if (csr_addr == 2'd0) begin
                    mie  <= csr_wdata[3];
                    mpie <= csr_wdata[7];
                end
                if (csr_addr == 2'd1) mtvec <= {csr_wdata[31:2], 2'b00};
                if (csr_addr == 2'd2) mepc <= csr_wdata;
                if (csr_addr == 2'd3) mcause <= csr_wdata;
            end
        end
    end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode exception/interrupt controller; the consumer side of the ALU overflow flag and the other decode-time fault flags.
- Prioritises sync exceptions and the external interrupt, then cancels the faulting instruction's side effects.
- Captures mepc/mcause, updates mstatus, and issues a registered PC redirect to mtvec, or to mepc on mret.
- Sits beside the single-cycle datapath's next-PC mux; holds the 4 CSRs.

Parameters:
VEC_BASE, 32'h0000_0008, reset value of mtvec (bits [1:0] must be 0)
SYNC_STAGES, 2, flops in ext_irq synchronizer (>=2)

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
pc  in  32  PC of instruction in execute this cycle
inst_valid  in  1  instruction in execute is real (not bubble/killed)
ov  in  1  ALU overflow flag
ov_chk  in  1  instruction is a trapping signed add/sub
ill  in  1  illegal instruction decoded
ecall  in  1  ecall decoded
mret  in  1  mret decoded
ext_irq  in  1  asynchronous level external interrupt
csr_we  in  1  CSR write strobe
csr_addr  in  2  0 mstatus, 1 mtvec, 2 mepc, 3 mcause
csr_wdata  in  32  CSR write data
csr_rdata  out  32  combinational read of csr_addr
cancel  out  1  combinational: suppress regfile/mem/CSR write this cycle
redirect  out  1  registered: next PC = redirect_pc
redirect_pc  out  32  registered redirect target

Behaviour:
- Reset (async, clrn=0):
  - state=RUN; mstatus=0; mtvec=VEC_BASE; mepc=0; mcause=0.
  - redirect=0; redirect_pc=0; synchronizer flops=0.
  - Reset applies immediately, including mid-redirect.
- mstatus: only MIE=bit3 and MPIE=bit7 are stored; all other bits read 0 and ignore writes.
- mtvec write: bits [1:0] forced 0.
- irq_s = ext_irq after SYNC_STAGES flops (level).
- States: RUN, REDIR.
- RUN, event = inst_valid & (exc | int | mret). Priority is highest first:
  - ill: cause 32'h2
  - ecall: cause 32'hB
  - ov_chk&ov: cause 32'h18
  - irq_s&MIE: cause 32'h8000_000B
  - mret
- Trap (exc or int):
  - cancel=1 the same cycle.
  - At the edge: mepc<=pc; mcause<=cause; MPIE<=MIE; MIE<=0; redirect_pc<=mtvec; redirect<=1; state<=REDIR.
- mret with no trap pending:
  - cancel=0.
  - At the edge: MIE<=MPIE; MPIE<=1; redirect_pc<=mepc; redirect<=1; state<=REDIR.
- Interrupt coincident with mret: the interrupt wins. mret is cancelled; mepc=pc of the mret.
- REDIR:
  - Lasts exactly 1 cycle; redirect=1.
  - cancel=1 (the wrong-path instruction is killed); all event inputs ignored.
  - Next edge: redirect<=0, state<=RUN.
- CSR write:
  - Applied at the edge only when csr_we & inst_valid & ~cancel.
  - A trap or mret in the same cycle overrides and drops the write.
- inst_valid=0 in RUN: no event taken; irq stays pending (level, not latched).
- csr_rdata reflects the current register values, not same-cycle writes.
- Redirect latency: 1 cycle after the event cycle.

Optional Feature:
OV_TRAP_EN
- Defined: ov_chk&ov raises the overflow exception (cause 32'h18) as above.
- Undefined:
  - ov and ov_chk are ignored.
  - Cause 32'h18 is never produced.
  - Overflowing add/sub commit normally with cancel=0.

Test Plan:
1. Reset: clrn=0 mid-cycle, then release -> mtvec reads 0x8; mstatus/mepc/mcause read 0; redirect=0; cancel=0.
2. OV_TRAP_EN: pc=0x40, inst_valid=1, ov_chk=1, ov=1 -> cancel=1 same cycle. Next cycle: redirect=1, redirect_pc=0x8, mepc=0x40, mcause=0x18. Following cycle: redirect=0.
3. csr write mstatus=0x8, then ext_irq=1 with inst_valid=1 at pc=0x100 -> cancel within SYNC_STAGES+1 cycles; mepc=0x100; mcause=0x8000000B; mstatus=0x80.
4. ill=1, ecall=1, ov_chk=ov=1 at pc=0x20 -> mcause=0x2. Same stimulus with inst_valid=0 -> no cancel, no redirect.
5. mepc=0x44, mstatus=0x80, mret=1 -> cancel=0. Next cycle: redirect_pc=0x44; mstatus=0x88.
6. csr_we to mtvec=0x203 coincident with ecall -> mtvec unchanged, mcause=0xB. Then clrn=0 during REDIR -> redirect drops to 0 immediately.
